// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: operand fetch + ID/EX pipeline register.
// Selects each source operand from EX (forward flag), MEM, WB or the register
// file, inserts a bubble on load-use hazards and counts those stall cycles.

// Per-operand bypass mux. The EX hit only raises a flag; the value is
// substituted inside EX, so the operand itself is driven to 0.
module id_ex_opsel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_idx,
  input  logic              i_ex_fwdable,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_wr_en,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_result,
  input  logic              i_wb_wr_en,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [DATA_W-1:0] o_val,
  output logic              o_fwd
);
  // Priority EX > MEM > WB > register file; index 0 always reads as zero
  always_comb begin
    o_val = '0;
    o_fwd = 1'b0;
    if (i_idx != '0) begin
      if (i_ex_fwdable && i_ex_rd == i_idx)       o_fwd = 1'b1;
      else if (i_mem_wr_en && i_mem_rd == i_idx)  o_val = i_mem_result;
      else if (i_wb_wr_en && i_wb_rd == i_idx)    o_val = i_wb_data;
      else                                        o_val = i_rf_data;
    end
  end
endmodule

module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [REG_AW-1:0] rf_rs,
  output logic [REG_AW-1:0] rf_rt,
  input  logic [DATA_W-1:0] rf_data_rs,
  input  logic [DATA_W-1:0] rf_data_rt,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_fwd_a,
  output logic              ex_fwd_b,
  output logic [15:0]       stall_count
);
  logic              r_ex_valid, r_ex_wr_en, r_ex_is_load, r_ex_fwd_a, r_ex_fwd_b;
  logic [REG_AW-1:0] r_ex_rd;
  logic [DATA_W-1:0] r_ex_op_a, r_ex_op_b;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [15:0]       r_stall_count;

  logic [1:0][REG_AW-1:0] w_idx;
  logic [1:0][DATA_W-1:0] w_rf;
  logic [1:0][DATA_W-1:0] w_val;
  logic [1:0]             w_fwd;
  logic                   w_ex_fwdable;
  logic                   w_hazard;

  assign rf_rs = id_rs;
  assign rf_rt = id_rt;

  // A load's result is not available from EX, so it never forwards from there
  assign w_ex_fwdable = r_ex_valid & r_ex_wr_en & ~r_ex_is_load;
  assign w_idx = {id_rt, id_rs};
  assign w_rf  = {rf_data_rt, rf_data_rs};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_op
      id_ex_opsel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_sel (
        .i_idx        (w_idx[g]),
        .i_ex_fwdable (w_ex_fwdable),
        .i_ex_rd      (r_ex_rd),
        .i_mem_wr_en  (mem_wr_en),
        .i_mem_rd     (mem_rd),
        .i_mem_result (mem_result),
        .i_wb_wr_en   (wb_wr_en),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .i_rf_data    (w_rf[g]),
        .o_val        (w_val[g]),
        .o_fwd        (w_fwd[g])
      );
    end
  endgenerate

  assign w_hazard = id_valid & r_ex_valid & r_ex_is_load & r_ex_wr_en & (r_ex_rd != '0) &
                    ((id_uses_rs & (id_rs == r_ex_rd)) | (id_uses_rt & (id_rt == r_ex_rd)));

  assign id_stall = ~flush & (~ex_ready | w_hazard);

  // ID/EX register: reset > flush > backpressure hold > load-use bubble > capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_wr_en    <= 1'b0;
      r_ex_is_load  <= 1'b0;
      r_ex_fwd_a    <= 1'b0;
      r_ex_fwd_b    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_op_a     <= '0;
      r_ex_op_b     <= '0;
      r_ex_ctrl     <= '0;
      r_stall_count <= '0;
    end else if (flush || (ex_ready && w_hazard)) begin
      r_ex_valid   <= 1'b0;
      r_ex_wr_en   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_fwd_a   <= 1'b0;
      r_ex_fwd_b   <= 1'b0;
      // Only real load-use bubbles are counted, never flushes or holds
      if (!flush && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
    end else if (ex_ready) begin
      r_ex_valid   <= id_valid;
      r_ex_wr_en   <= id_wr_en;
      r_ex_is_load <= id_is_load;
      r_ex_fwd_a   <= w_fwd[0];
      r_ex_fwd_b   <= w_fwd[1];
      r_ex_rd      <= id_rd;
      r_ex_op_a    <= w_val[0];
      r_ex_op_b    <= w_val[1];
      r_ex_ctrl    <= id_ctrl;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_wr_en    = r_ex_wr_en;
  assign ex_is_load  = r_ex_is_load;
  assign ex_rd       = r_ex_rd;
  assign ex_op_a     = r_ex_op_a;
  assign ex_op_b     = r_ex_op_b;
  assign ex_ctrl     = r_ex_ctrl;
  assign ex_fwd_a    = r_ex_fwd_a;
  assign ex_fwd_b    = r_ex_fwd_b;
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX contents are queued
// when an instruction is presented and compared after the capturing edge.
module tb_id_ex_operand_stage;
  localparam int DW = 32, AW = 5, CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
  logic [AW-1:0] id_rs, id_rt, id_rd, rf_rs, rf_rt, mem_rd, wb_rd, ex_rd;
  logic [CW-1:0] id_ctrl, ex_ctrl;
  logic [DW-1:0] rf_data_rs, rf_data_rt, mem_result, wb_data, ex_op_a, ex_op_b;
  logic          mem_wr_en, wb_wr_en, ex_ready, flush, id_stall;
  logic          ex_valid, ex_wr_en, ex_is_load, ex_fwd_a, ex_fwd_b;
  logic [15:0]   stall_count;

  logic [DW-1:0] regs [32];
  assign rf_data_rs = regs[rf_rs];
  assign rf_data_rt = regs[rf_rt];

  id_ex_operand_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_data_rs(rf_data_rs), .rf_data_rt(rf_data_rt), .mem_wr_en(mem_wr_en),
    .mem_rd(mem_rd), .mem_result(mem_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_ctrl(ex_ctrl), .ex_fwd_a(ex_fwd_a),
    .ex_fwd_b(ex_fwd_b), .stall_count(stall_count)
  );

  typedef struct {
    bit            dc;  // data fields don't-care (bubble)
    logic          valid, wr, ld, fa, fb;
    logic [AW-1:0] rd;
    logic [DW-1:0] a, b;
    logic [CW-1:0] ctrl;
    logic [15:0]   cnt;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_wr_en = 1'b0; id_is_load = 1'b0; id_ctrl = '0;
    mem_wr_en = 1'b0; mem_rd = '0; mem_result = '0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [AW-1:0] rs, rt, rd, input logic urs, urt, wr, ld,
                       input logic [CW-1:0] ctrl);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_wr_en = wr; id_is_load = ld; id_ctrl = ctrl;
  endtask

  // Expect the currently presented ID instruction to be captured
  task automatic exp_cap(input logic [DW-1:0] a, b, input logic fa, fb, input logic [15:0] cnt);
    exp_t e;
    e.dc = 1'b0; e.valid = id_valid; e.wr = id_wr_en; e.ld = id_is_load; e.rd = id_rd;
    e.ctrl = id_ctrl; e.a = a; e.b = b; e.fa = fa; e.fb = fb; e.cnt = cnt;
    q.push_back(e); last = e;
  endtask

  task automatic exp_bubble(input logic [15:0] cnt);
    exp_t e;
    e.dc = 1'b1; e.valid = 1'b0; e.wr = 1'b0; e.ld = 1'b0; e.rd = '0;
    e.ctrl = '0; e.a = '0; e.b = '0; e.fa = 1'b0; e.fb = 1'b0; e.cnt = cnt;
    q.push_back(e); last = e;
  endtask

  task automatic exp_zero();
    exp_t e;
    e.dc = 1'b0; e.valid = 1'b0; e.wr = 1'b0; e.ld = 1'b0; e.rd = '0;
    e.ctrl = '0; e.a = '0; e.b = '0; e.fa = 1'b0; e.fb = 1'b0; e.cnt = '0;
    q.push_back(e); last = e;
  endtask

  task automatic exp_hold();
    q.push_back(last);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk(tag, {63'd0, id_stall}, {63'd0, exp});
  endtask

  // One clock edge, then score the EX register against the oldest expectation
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
      chk("ex_wr_en", {63'd0, ex_wr_en}, {63'd0, e.wr});
      chk("ex_is_load", {63'd0, ex_is_load}, {63'd0, e.ld});
      chk("ex_fwd_a", {63'd0, ex_fwd_a}, {63'd0, e.fa});
      chk("ex_fwd_b", {63'd0, ex_fwd_b}, {63'd0, e.fb});
      chk("stall_count", {48'd0, stall_count}, {48'd0, e.cnt});
      if (!e.dc) begin
        chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
        chk("ex_op_a", {32'd0, ex_op_a}, {32'd0, e.a});
        chk("ex_op_b", {32'd0, ex_op_b}, {32'd0, e.b});
        chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, e.ctrl});
      end
    end
    @(negedge clk);
  endtask

  // Reference operand selection against the EX state the bench itself tracks
  logic          pv, pw;
  logic [AW-1:0] prd;
  task automatic ref_op(input logic [AW-1:0] idx, output logic [DW-1:0] v, output logic f);
    v = '0; f = 1'b0;
    if (idx == 0) begin
      v = '0;
    end else if (pv && pw && prd == idx) begin
      f = 1'b1;
    end else if (mem_wr_en && mem_rd == idx) begin
      v = mem_result;
    end else if (wb_wr_en && wb_rd == idx) begin
      v = wb_data;
    end else begin
      v = regs[idx];
    end
  endtask

  initial begin
    logic [DW-1:0] ea, eb;
    logic          fa, fb;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_0000;  // must never leak through index 0
    idle();
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rst = 1'b0; ex_ready = 1'b1; flush = 1'($urandom);
      id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_wr_en = 1'($urandom); id_is_load = 1'($urandom); id_ctrl = 8'($urandom);
      mem_wr_en = 1'($urandom); mem_rd = 5'($urandom); mem_result = $urandom;
      wb_wr_en = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      exp_zero();
      step();
      chk_stall("rst_id_stall", 1'b0);
    end
    idle();

    // Register-file path, index 0 reads zero
    regs[5] = 32'h0000_1234;
    issue(5, 0, 9, 1, 1, 1, 0, 8'h5A);
    #1;
    chk("rf_rs", {59'd0, rf_rs}, 64'd5);
    chk("rf_rt", {59'd0, rf_rt}, 64'd0);
    exp_cap(32'h1234, 0, 0, 0, 0);
    step();

    // Bypass priority MEM > WB > register file
    regs[7] = 32'h0000_1111;
    issue(7, 0, 0, 1, 0, 0, 0, 8'h11);
    mem_wr_en = 1; mem_rd = 7; mem_result = 32'hBBBB;
    wb_wr_en = 1; wb_rd = 7; wb_data = 32'hAAAA;
    exp_cap(32'hBBBB, 0, 0, 0, 0);
    step();
    mem_wr_en = 0;
    exp_cap(32'hAAAA, 0, 0, 0, 0);
    step();
    wb_wr_en = 0;
    exp_cap(32'h1111, 0, 0, 0, 0);
    step();

    // EX forward beats a matching MEM write; then rd=0 never forwards
    issue(0, 0, 3, 0, 0, 1, 0, 8'h22);
    exp_cap(0, 0, 0, 0, 0);
    step();
    issue(0, 3, 0, 0, 1, 0, 0, 8'h23);
    mem_wr_en = 1; mem_rd = 3; mem_result = 32'hCCCC;
    chk_stall("fwd_no_stall", 1'b0);
    exp_cap(0, 0, 0, 1, 0);
    step();
    issue(0, 0, 0, 0, 0, 1, 0, 8'h24);
    exp_cap(0, 0, 0, 0, 0);
    step();
    issue(0, 0, 0, 0, 1, 0, 0, 8'h25);
    mem_rd = 0;
    exp_cap(0, 0, 0, 0, 0);
    step();
    mem_wr_en = 0;

    // Load-use: one bubble, then operand from MEM
    issue(0, 0, 4, 0, 0, 1, 1, 8'h30);
    exp_cap(0, 0, 0, 0, 0);
    step();
    issue(4, 0, 6, 1, 0, 1, 0, 8'h31);
    chk_stall("lu_stall_on", 1'b1);
    exp_bubble(1);
    step();
    mem_wr_en = 1; mem_rd = 4; mem_result = 32'h4444;
    chk_stall("lu_stall_off", 1'b0);
    exp_cap(32'h4444, 0, 0, 0, 1);
    step();
    mem_wr_en = 0;

    // Backpressure with a hazard present, then flush over the hazard
    issue(0, 0, 8, 0, 0, 1, 1, 8'h40);
    exp_cap(0, 0, 0, 0, 1);
    step();
    issue(0, 8, 2, 0, 1, 1, 0, 8'h41);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk_stall("bp_stall", 1'b1);
      exp_hold();
      step();
    end
    ex_ready = 1; flush = 1;
    chk_stall("flush_no_stall", 1'b0);
    exp_bubble(1);
    step();
    flush = 0;

    // Reset on the hazard cycle clears everything; re-presented instr captures
    regs[10] = 32'h0000_A0A0;
    issue(0, 0, 10, 0, 0, 1, 1, 8'h50);
    exp_cap(0, 0, 0, 0, 1);
    step();
    issue(10, 0, 11, 1, 0, 1, 0, 8'h51);
    rst = 0;
    exp_zero();
    step();
    rst = 1;
    chk_stall("post_rst_stall", 1'b0);
    exp_cap(32'hA0A0, 0, 0, 0, 0);
    step();

    // Saturation: preload counter next to the limit, then two more hazards
    force dut.r_stall_count = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    for (int k = 0; k < 2; k++) begin
      issue(0, 0, 4, 0, 0, 1, 1, 8'h60);
      exp_cap(0, 0, 0, 0, (k == 0) ? 16'hFFFE : 16'hFFFF);
      step();
      issue(4, 0, 6, 1, 0, 1, 0, 8'h61);
      exp_bubble(16'hFFFF);
      step();
      mem_wr_en = 1; mem_rd = 4; mem_result = 32'h5555;
      exp_cap(32'h5555, 0, 0, 0, 16'hFFFF);
      step();
      mem_wr_en = 0;
    end

    // Random bypass traffic (no loads), checked against the reference selector
    idle();
    exp_cap(0, 0, 0, 0, 16'hFFFF);
    step();
    pv = 0; pw = 0; prd = 0;
    for (int i = 0; i < 60; i++) begin
      id_valid = 1'($urandom); id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7)); id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_wr_en = 1'($urandom); id_is_load = 1'b0; id_ctrl = 8'($urandom);
      mem_wr_en = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_wr_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      ref_op(id_rs, ea, fa);
      ref_op(id_rt, eb, fb);
      exp_cap(ea, eb, fa, fb, 16'hFFFF);
      step();
      pv = id_valid; pw = id_wr_en; prd = id_rd;
    end

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Operand-fetch and ID/EX pipeline register for the core. It drives the `register_file` read addresses from the decoded instruction and captures `data_rs`/`data_rt` into the EX stage. It bypasses results from the MEM and WB stages and flags EX-to-EX forwarding. It also detects load-use hazards, inserts a one-cycle bubble for each, and counts the resulting stall cycles.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register index width
- CTRL_W, 8, opaque control bundle carried to EX
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low (`rst`=0 resets on the next rising edge)
- id_valid  in  1  decoded instruction present
- id_rs, id_rt, id_rd  in  REG_AW  source/destination indices
- id_uses_rs, id_uses_rt  in  1  source operand actually read
- id_wr_en, id_is_load  in  1  instruction writes rd / is a load
- id_ctrl  in  CTRL_W  passthrough control
- rf_rs, rf_rt  out  REG_AW  read addresses to `register_file`; combinational copies of id_rs/id_rt
- rf_data_rs, rf_data_rt  in  DATA_W  register-file read data
- mem_wr_en, mem_rd, mem_result  in  1/REG_AW/DATA_W  MEM-stage pending write
- wb_wr_en, wb_rd, wb_data  in  1/REG_AW/DATA_W  WB write; same signals as the register-file `en`/`rd`/`data`
- ex_ready  in  1  EX accepts new contents
- flush  in  1  kill the instruction entering EX
- id_stall  out  1  hold IF/ID
- ex_valid, ex_wr_en, ex_is_load  out  1  registered
- ex_rd  out  REG_AW; ex_op_a, ex_op_b  out  DATA_W; ex_ctrl  out  CTRL_W  registered
- ex_fwd_a, ex_fwd_b  out  1  registered; EX must substitute its own previous ALU result
- stall_count  out  16  load-use stall cycles, saturating

## Operation
- `register_file` writes at the clock edge, and a same-cycle read returns the old value. This block therefore bypasses the WB write itself.
- Per source operand (A from rs, B from rt), the match conditions are:
  - Index 0 → operand 0, no forwarding.
  - EX match: ex_valid & ex_wr_en & !ex_is_load & ex_rd==idx → ex_fwd=1, operand value don't-care (0 driven).
  - Else MEM match: mem_wr_en & mem_rd==idx → mem_result.
  - Else WB match: wb_wr_en & wb_rd==idx → wb_data.
  - Else rf_data.
- Priority among matches: EX > MEM > WB > register file. A used operand with unused flag (id_uses_*=0) still selects by the same rules; the value is don't-care.
- Load-use hazard: `hazard = id_valid & ex_valid & ex_is_load & ex_wr_en & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- Edge behaviour, evaluated in priority order:
  1. rst=0 → all registered outputs 0, stall_count 0.
  2. flush=1 → ex_valid, ex_wr_en, ex_is_load, ex_fwd_* cleared (bubble). Data fields don't-care.
  3. ex_ready=0 → all EX registers hold.
  4. hazard → bubble loaded, as in case 2.
  5. Otherwise → capture the ID instruction; ex_valid=id_valid.
- `id_stall = !flush & (!ex_ready | hazard)`, combinational.
- stall_count increments on each edge taken through case 4 and saturates at 0xFFFF. It does not count !ex_ready cycles.

## Timing
- Latency: ID inputs to ex_* outputs is 1 cycle.
- rf_rs/rf_rt have zero latency (combinational).
- After a load-use hazard, the dependent instruction is held one cycle. The load is then in MEM, and the operand is taken from mem_result.
- Reset values: all ex_* outputs 0, stall_count 0. id_stall is combinational from the inputs and ex_* state.
- Reset asserted mid-stall clears the bubble state. The dependent instruction re-presented after reset captures normally.
- Simultaneous flush and hazard: flush wins, id_stall=0, stall_count unchanged.
- ex_ready=0 together with hazard: hold, stall_count unchanged. id_stall=1.

## Test plan
- Reset: rst=0 for 2 cycles with random inputs → all ex_* = 0, stall_count=0, id_stall=0 while ex_ready=1.
- Register-file path: r5=0x1234 in the register file, no pending writes, issue rs=5 rt=0 → next cycle ex_op_a=0x1234, ex_op_b=0, ex_fwd_a=0.
- Bypass priority: WB writes r7=0xAAAA and MEM holds r7=0xBBBB in the same cycle, issue rs=7 → ex_op_a=0xBBBB. MEM write removed → 0xAAAA. This confirms WB bypasses the register file's old-value read.
- EX forward: ALU op writing r3 in EX, next instruction reads rt=3 → ex_fwd_b=1, no stall. Same case with rd=0 → ex_fwd_b=0, ex_op_b=0.
- Load-use: load to r4 in EX, next instruction uses rs=4 → id_stall=1 for exactly one cycle, bubble (ex_valid=0), stall_count 0→1. The following cycle captures ex_op_a=mem_result.
- Backpressure and flush: ex_ready=0 for 3 cycles → ex_* hold, id_stall=1, stall_count unchanged. flush=1 with a hazard present → ex_valid=0, id_stall=0, count unchanged. Force 65 536 hazards → stall_count stays 0xFFFF.
